intra_ang_pos_gen: RTL and testbench

Per-line reference-position generator for HEVC intra angular prediction. It sits directly downstream of the mode-to-angle mapper. It takes one block's signed `angle` (range −32..32), its size and its direction. It then emits, one line per cycle, the integer reference offset `idx` and the 1/32 fractional weight `fact` used by the sample interpolator. It also reports the block's inverse angle, which the reference-extension logic needs when the angle is negative.

---
 rtl/intra_ang_pos_gen_if.sv | 33 +++
 rtl/intra_ang_pos_gen.sv | 144 ++++++++++++++
 tb/tb_intra_ang_pos_gen.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/intra_ang_pos_gen_if.sv
// Descriptor and line-output bundle for intra_ang_pos_gen.
//   start_*      : block descriptor handshake (angle, size code, direction)
//   out_*        : per-line reference offset / fractional weight stream
//   inv_angle    : inverse angle of the accepted block (0 for angle >= 0)
// slave  modport : the generator side
// master modport : the upstream/downstream environment side
interface intra_ang_pos_gen_if;
    logic        start_valid;
    logic        start_ready;
    logic [6:0]  angle;
    logic [1:0]  log2_size_m2;
    logic        is_hor;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_line;
    logic [6:0]  out_idx;
    logic [4:0]  out_fact;
    logic        out_last;
    logic        out_is_hor;
    logic [12:0] inv_angle;

    modport slave (
        input  start_valid, angle, log2_size_m2, is_hor, out_ready,
        output start_ready, out_valid, out_line, out_idx, out_fact,
               out_last, out_is_hor, inv_angle
    );

    modport master (
        output start_valid, angle, log2_size_m2, is_hor, out_ready,
        input  start_ready, out_valid, out_line, out_idx, out_fact,
               out_last, out_is_hor, inv_angle
    );
endinterface

// File: rtl/intra_ang_pos_gen.sv
// Per-line reference-position generator for HEVC intra angular prediction.
// Accepts one block descriptor (angle, size, direction) and streams one line
// per cycle: idx = ((y+1)*angle) >>> 5, fact = ((y+1)*angle) & 31, computed
// by accumulating the angle rather than multiplying.
// Ports:
//   clk    : clock, rising edge
//   rst_n  : synchronous active-low reset
//   bus    : descriptor/line interface (slave side), see intra_ang_pos_gen_if
module intra_ang_pos_gen (
    input  logic                clk,
    input  logic                rst_n,
    intra_ang_pos_gen_if.slave  bus
);

    localparam int unsigned ANG_W  = 7;
    localparam int unsigned POS_W  = 12;
    localparam int unsigned LINE_W = 5;
    localparam int unsigned INV_W  = 13;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e             state_q,     state_d;
    logic [ANG_W-1:0]   angle_q,     angle_d;
    logic [LINE_W-1:0]  n_m1_q,      n_m1_d;
    logic [LINE_W-1:0]  line_q,      line_d;
    logic [POS_W-1:0]   pos_q,       pos_d;
    logic               out_valid_q, out_valid_d;
    logic               out_last_q,  out_last_d;
    logic               is_hor_q,    is_hor_d;
    logic [INV_W-1:0]   inv_angle_q, inv_angle_d;

    logic [INV_W-1:0]   inv_lut_c;
    logic [LINE_W-1:0]  n_m1_c;
    logic [LINE_W-1:0]  line_inc_c;

    // Inverse-angle table, indexed by the raw two's-complement angle code
    always_comb begin
        inv_lut_c = '0;
        case (bus.angle)
            7'h60:   inv_lut_c = INV_W'(-256);   // -32
            7'h66:   inv_lut_c = INV_W'(-315);   // -26
            7'h6B:   inv_lut_c = INV_W'(-390);   // -21
            7'h6F:   inv_lut_c = INV_W'(-482);   // -17
            7'h73:   inv_lut_c = INV_W'(-630);   // -13
            7'h77:   inv_lut_c = INV_W'(-910);   // -9
            7'h7B:   inv_lut_c = INV_W'(-1638);  // -5
            7'h7E:   inv_lut_c = INV_W'(-4096);  // -2
            default: inv_lut_c = '0;
        endcase
    end

    // Last line index for the requested block size
    always_comb begin
        case (bus.log2_size_m2)
            2'd0:    n_m1_c = LINE_W'(3);
            2'd1:    n_m1_c = LINE_W'(7);
            2'd2:    n_m1_c = LINE_W'(15);
            default: n_m1_c = LINE_W'(31);
        endcase
    end

    assign line_inc_c = line_q + LINE_W'(1);

    // Next-state and datapath update
    always_comb begin
        state_d     = state_q;
        angle_d     = angle_q;
        n_m1_d      = n_m1_q;
        line_d      = line_q;
        pos_d       = pos_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        is_hor_d    = is_hor_q;
        inv_angle_d = inv_angle_q;

        case (state_q)
            IDLE: begin
                if (bus.start_valid) begin
                    state_d     = RUN;
                    angle_d     = bus.angle;
                    n_m1_d      = n_m1_c;
                    is_hor_d    = bus.is_hor;
                    pos_d       = {{(POS_W-ANG_W){bus.angle[ANG_W-1]}}, bus.angle};
                    line_d      = '0;
                    out_valid_d = 1'b1;
                    out_last_d  = 1'b0;   // smallest block has 4 lines
                    inv_angle_d = inv_lut_c;
                end
            end
            RUN: begin
                // out_valid is always high in RUN, so out_ready alone completes a line
                if (bus.out_ready) begin
                    if (line_q == n_m1_q) begin
                        state_d     = IDLE;
                        out_valid_d = 1'b0;
                    end else begin
                        line_d     = line_inc_c;
                        pos_d      = pos_q + {{(POS_W-ANG_W){angle_q[ANG_W-1]}}, angle_q};
                        out_last_d = (line_inc_c == n_m1_q);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            angle_q     <= '0;
            n_m1_q      <= '0;
            line_q      <= '0;
            pos_q       <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            is_hor_q    <= 1'b0;
            inv_angle_q <= '0;
        end else begin
            state_q     <= state_d;
            angle_q     <= angle_d;
            n_m1_q      <= n_m1_d;
            line_q      <= line_d;
            pos_q       <= pos_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            is_hor_q    <= is_hor_d;
            inv_angle_q <= inv_angle_d;
        end
    end

    assign bus.start_ready = (state_q == IDLE);
    assign bus.out_valid   = out_valid_q;
    assign bus.out_line    = line_q;
    assign bus.out_idx     = pos_q[11:5];
    assign bus.out_fact    = pos_q[4:0];
    assign bus.out_last    = out_last_q;
    assign bus.out_is_hor  = is_hor_q;
    assign bus.inv_angle   = inv_angle_q;

endmodule

// File: tb/tb_intra_ang_pos_gen.sv
// Directed bench for intra_ang_pos_gen: streams blocks of several angles and
// sizes, checks every line against (y+1)*angle, and spot-checks hand values.
module tb_intra_ang_pos_gen;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;
    int   obs_idx  [32];
    int   obs_fact [32];

    intra_ang_pos_gen_if bus ();

    intra_ang_pos_gen dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_idle_reset(input string tag);
        check({tag, " out_valid"},   int'(bus.out_valid), 0);
        check({tag, " start_ready"}, int'(bus.start_ready), 1);
        check({tag, " out_line"},    int'(bus.out_line), 0);
        check({tag, " out_idx"},     int'($signed(bus.out_idx)), 0);
        check({tag, " out_fact"},    int'(bus.out_fact), 0);
        check({tag, " out_last"},    int'(bus.out_last), 0);
        check({tag, " out_is_hor"},  int'(bus.out_is_hor), 0);
        check({tag, " inv_angle"},   int'($signed(bus.inv_angle)), 0);
    endtask

    // Checks every output of line y of a block with the given angle
    task automatic check_line(input string tag, input int ang, input int n,
                              input int y, input bit hor, input int exp_inv);
        int p;
        p = (y + 1) * ang;
        check({tag, " out_valid"},  int'(bus.out_valid), 1);
        check({tag, " out_line"},   int'(bus.out_line), y);
        check({tag, " out_idx"},    int'($signed(bus.out_idx)), p >>> 5);
        check({tag, " out_fact"},   int'(bus.out_fact), p & 31);
        check({tag, " out_last"},   int'(bus.out_last), (y == n - 1) ? 1 : 0);
        check({tag, " out_is_hor"}, int'(bus.out_is_hor), int'(hor));
        check({tag, " inv_angle"},  int'($signed(bus.inv_angle)), exp_inv);
    endtask

    // Runs one block; optional stall on stall_line, reset on rst_line,
    // and start_valid kept high for the whole block when hold_start is set.
    task automatic run_block(input int ang, input int code, input bit hor,
                             input int exp_inv, input int stall_line,
                             input int rst_line, input bit hold_start);
        int    n;
        int    budget;
        string tag;
        n = 4 << code;
        @(negedge clk);
        bus.start_valid  = 1'b1;
        bus.angle        = 7'(ang);
        bus.log2_size_m2 = 2'(code);
        bus.is_hor       = hor;
        budget = 0;
        while (!bus.start_ready && budget < 100) begin
            @(negedge clk);
            budget++;
        end
        check($sformatf("a%0d start wait", ang), int'(budget < 100), 1);
        @(negedge clk);
        if (!hold_start) bus.start_valid = 1'b0;
        for (int y = 0; y < n; y++) begin
            tag = $sformatf("a%0d n%0d y%0d", ang, n, y);
            check_line(tag, ang, n, y, hor, exp_inv);
            obs_idx[y]  = int'($signed(bus.out_idx));
            obs_fact[y] = int'(bus.out_fact);
            if (hold_start) check({tag, " start_ready"}, int'(bus.start_ready), 0);
            if (y == rst_line) begin
                rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                check_idle_reset({tag, " mid-reset"});
                return;
            end
            if (y == stall_line) begin
                bus.out_ready = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    check_line({tag, " stall"}, ang, n, y, hor, exp_inv);
                end
                bus.out_ready = 1'b1;
            end
            @(negedge clk);
        end
        tag = $sformatf("a%0d n%0d done", ang, n);
        check({tag, " out_valid"},   int'(bus.out_valid), 0);
        check({tag, " start_ready"}, int'(bus.start_ready), 1);
        check({tag, " inv_angle"},   int'($signed(bus.inv_angle)), exp_inv);
        check({tag, " out_is_hor"},  int'(bus.out_is_hor), int'(hor));
        bus.start_valid = 1'b0;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n            = 1'b0;
        bus.start_valid  = 1'b0;
        bus.angle        = '0;
        bus.log2_size_m2 = '0;
        bus.is_hor       = 1'b0;
        bus.out_ready    = 1'b1;
        repeat (3) @(negedge clk);
        check_idle_reset("reset");
        rst_n = 1'b1;

        // angle 32, size 4
        run_block(32, 0, 1'b0, 0, -1, -1, 1'b0);
        for (int y = 0; y < 4; y++) begin
            check($sformatf("a32 hand idx%0d", y), obs_idx[y], y + 1);
            check($sformatf("a32 hand fact%0d", y), obs_fact[y], 0);
        end

        // angle -9, size 8, horizontal
        run_block(-9, 1, 1'b1, -910, -1, -1, 1'b0);
        check("a-9 hand idx0", obs_idx[0], -1);
        check("a-9 hand fact0", obs_fact[0], 23);
        check("a-9 hand idx1", obs_idx[1], -1);
        check("a-9 hand fact1", obs_fact[1], 14);
        check("a-9 hand idx7", obs_idx[7], -3);
        check("a-9 hand fact7", obs_fact[7], 24);

        // angle 13, size 4, back-pressure on line 1
        run_block(13, 0, 1'b0, 0, 1, -1, 1'b0);
        check("a13 hand idx1", obs_idx[1], 0);
        check("a13 hand fact1", obs_fact[1], 26);
        check("a13 hand idx2", obs_idx[2], 1);
        check("a13 hand fact2", obs_fact[2], 7);

        // angle 0, size 32, start_valid held high during the block
        run_block(0, 3, 1'b0, 0, -1, -1, 1'b1);
        check("a0 hand idx31", obs_idx[31], 0);
        check("a0 hand fact31", obs_fact[31], 0);

        // angle 2, size 16, horizontal
        run_block(2, 2, 1'b1, 0, -1, -1, 1'b0);
        check("a2 hand idx15", obs_idx[15], 1);
        check("a2 hand fact15", obs_fact[15], 0);
        check("a2 hand idx14", obs_idx[14], 0);
        check("a2 hand fact14", obs_fact[14], 30);

        // angle -32, size 16, reset while line 5 is presented
        run_block(-32, 2, 1'b0, -256, -1, 5, 1'b0);

        // clean restart after reset: angle 5, size 4
        run_block(5, 0, 1'b0, 0, -1, -1, 1'b0);
        check("a5 hand idx0", obs_idx[0], 0);
        check("a5 hand fact0", obs_fact[0], 5);

        // illegal negative angle: arithmetic positions, zero inverse
        run_block(-7, 0, 1'b0, 0, -1, -1, 1'b0);
        check("a-7 hand idx3", obs_idx[3], -1);
        check("a-7 hand fact3", obs_fact[3], 4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
